// File: rtl/tx_polyfir.sv
// tx_polyfir: multi-channel polyphase pulse shaper, antipodal symbols, sign-select adder tree, saturating output
module tx_polyfir #(
    parameter int NCH = 2,
    parameter int OS = 4,
    parameter int NBAUD = 6,
    parameter int CW = 8,
    parameter int OW = 16,
    parameter logic [OS*NBAUD*CW-1:0] COEFS = 192'h18171615_14131211_100f0e0d_0c0b0a09_08070605_04030201
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic                    i_sym_vld,
    input  logic [NCH-1:0]          i_bits,
    output logic                    o_valid,
    output logic [NCH*OW-1:0]       o_data,
    output logic [$clog2(OS)-1:0]   o_phase
);
    localparam int PW = $clog2(OS);
    localparam int FW = CW + $clog2(NBAUD) + 1;
    localparam int NL = 1 << $clog2(NBAUD);

    logic [PW-1:0] ph;
    logic [1:0] line [NCH][NBAUD];
    logic [1:0] line_nx [NCH][NBAUD];
    logic [NCH*OW-1:0] samples;
    logic load;

    assign load = i_enable && ph == '0;

    // slot encoding: 00 = 0, 01 = +1, 11 = -1
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            line_nx[c][0] = !load ? line[c][0] : !i_sym_vld ? 2'b00 : i_bits[c] ? 2'b11 : 2'b01;
            for (int j = 1; j < NBAUD; j++)
                line_nx[c][j] = load ? line[c][j-1] : line[c][j];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [FW-1:0] node [1:2*NL-1];
        logic signed [OW-1:0] sat;
        // leaves at NL..2NL-1, root at 1
        always_comb begin
            for (int n = 1; n < 2*NL; n++)
                node[n] = '0;
            for (int j = 0; j < NBAUD; j++)
                node[NL+j] = line_nx[c][j] == 2'b01 ?  FW'($signed(COEFS[(j*OS + int'(ph))*CW +: CW])) :
                             line_nx[c][j] == 2'b11 ? -FW'($signed(COEFS[(j*OS + int'(ph))*CW +: CW])) : '0;
            for (int n = NL - 1; n >= 1; n--)
                node[n] = node[2*n] + node[2*n+1];
        end
        if (OW >= FW) begin : g_ext
            assign sat = OW'(node[1]);
        end else begin : g_sat
            localparam logic signed [FW-1:0] SMAX = FW'((2**(OW-1)) - 1);
            localparam logic signed [FW-1:0] SMIN = ~SMAX;
            assign sat = node[1] > SMAX ? OW'(SMAX) : node[1] < SMIN ? OW'(SMIN) : OW'(node[1]);
        end
        assign samples[c*OW +: OW] = sat;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ph <= '0;
            line <= '{default: '0};
            o_valid <= 1'b0;
            o_data <= '0;
            o_phase <= '0;
        end else begin
            o_valid <= i_enable;
            if (i_enable) begin
                ph <= ph == PW'(OS - 1) ? '0 : ph + 1'b1;
                line <= line_nx;
                o_data <= samples;
                o_phase <= ph;
            end
        end
    end
endmodule

// File: doc/tx_polyfir.md
# tx_polyfir

Parametrised multi-channel polyphase pulse-shaping transmitter; the single-clock successor to the QPSK `tx` block. It accepts one antipodal symbol per channel every `OS` enabled cycles and produces `OS` filtered samples per symbol from a tap set passed in by parameter. It sits between the PRBS sources and the DAC/output path. It adds three things over the first-generation block:
- a single clock with an enable strobe, replacing the separate symbol clock;
- configurable channel count, oversampling and span;
- zero-symbol insertion for flushing and impulse testing.

## Interface
Parameters:
- `NCH`, 2: number of independent channels (I/Q = 2).
- `OS`, 4: oversampling factor, samples per symbol (≥2).
- `NBAUD`, 6: filter span in symbols; tap count `NT = OS*NBAUD`.
- `CW`, 8: signed coefficient width.
- `OW`, 16: signed output sample width per channel.
- `COEFS`, `NT*CW` bits, default h[k]=k+1 for k=0..23: tap k is at `COEFS[k*CW +: CW]` and is shared by all channels.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset is synchronous and active-low.
- `i_enable`, in, 1: advances the phase counter and produces one output sample when high.
- `i_sym_vld`, in, 1: at a symbol-load cycle, 1 shifts in `i_bits` and 0 shifts in zero symbols.
- `i_bits`, in, `NCH`: one bit per channel; bit c belongs to channel c.
- `o_valid`, out, 1: `o_data` holds a new sample.
- `o_data`, out, `NCH*OW`: channel c sample at `[c*OW +: OW]`, two's complement.
- `o_phase`, out, `$clog2(OS)`: polyphase index of the sample on `o_data`.

## Operation
- **Phase counter** `ph`, range 0..OS-1.
  - Increments on each cycle with `i_enable`=1 and wraps from OS-1 to 0.
  - Holds when `i_enable`=0.
- **Symbol load** happens on a cycle with `i_enable`=1 and `ph`=0.
  - Each channel's NBAUD-entry symbol delay line shifts by one: s_j ← s_{j-1}, and the oldest symbol is discarded.
  - s_0 ← (`i_sym_vld` ? (`i_bits[c]` ? -1 : +1) : 0).
  - Symbol encoding is 2 bits per slot: {0, +1, -1}.
  - `i_sym_vld` and `i_bits` are ignored on non-load cycles.
- **Sample computation** on every enabled cycle, per channel, using the post-shift delay line:
  - y = Σ_{j=0..NBAUD-1} s_j · h[j*OS + ph].
  - A term is +h, -h or 0. No multipliers are used; implement as sign select plus adder tree.
- **Arithmetic**
  - Accumulate at full precision: `CW + $clog2(NBAUD) + 1` bits.
  - If OW is at least the full-precision width, sign-extend y to OW.
  - Otherwise saturate: clip to +(2^(OW-1)-1) or -2^(OW-1), with no wrap.
- **Reset** (`rst`=0 at a clock edge)
  - `ph` ← 0 and all delay-line slots ← 0.
  - `o_valid` ← 0, `o_data` ← 0, `o_phase` ← 0.
  - Reset has priority over `i_enable` and aborts a symbol period in progress. The first enabled cycle after release is a load cycle.
- **Enable low**: no state changes; `o_valid` ← 0; `o_data` and `o_phase` hold their last values.
- **Independence**: channels are fully independent and only share taps. NCH=1 is legal.

## Timing
- Output is registered with latency 1. For an enabled cycle at edge t, `o_valid`=1, `o_data` and `o_phase`=`ph` are visible after edge t+1.
- A symbol loaded at edge t first appears in the sample at edge t+1 with `o_phase`=0.
- A symbol contributes to exactly NT consecutive enabled samples and then leaves the delay line.
- Throughput is one sample per channel per enabled cycle, with no backpressure. A gapped `i_enable` stretches the symbol period without changing any sample value.
- `o_valid` is low in the cycle after any reset cycle and after any cycle with `i_enable`=0.
- The combinational adder depth is log2(NBAUD). Pipelining deeper is not permitted: latency is fixed at 1.

## Test plan
- **Reset values**: hold `rst`=0 for 4 cycles with random inputs, then release with `i_enable`=0 → `o_valid`=0, `o_data`=0, `o_phase`=0 throughout.
- **Impulse**: use default params.
  - Stimulus: at the first enabled cycle load `i_sym_vld`=1, `i_bits`=2'b10. Then `i_sym_vld`=0, with `i_enable` held at 1.
  - Channel 0 → 1,2,…,24 over 24 samples, then 0.
  - Channel 1 → -1,…,-24, then 0.
  - `o_phase` cycles 0,1,2,3.
- **Steady +1 stream**: `i_sym_vld`=1 and `i_bits`=0 every symbol. After 6 symbols, phase p → Σ_j h[4j+p] = 6p+66. That gives 66, 72, 78, 84, repeating.
- **Enable gaps**: repeat the impulse test with `i_enable` toggled pseudo-randomly (50%) → the same sample sequence on `o_valid`=1 cycles, with `o_valid`=0 on each cycle following `i_enable`=0.
- **Saturation**: OW=8, all taps 127, `i_bits`=0 for all symbols → output clips at 127 (full value 762). All-ones bits → -128.
- **Reset mid-symbol**: assert `rst`=0 with `ph`=2 and the line full → next enabled output has `o_phase`=0 and contains only the newly loaded symbol (impulse values restart at 1).
